// File: rtl/vote_collector.sv
// vote_collector: serial ballot collector feeding a 5-input one-hot voter.
// Accepts one-hot ballots over a valid/ready port and rejects malformed ones.
// It groups five accepted ballots into a frame and presents that frame on
// a0..a4 under a frame-valid/ack handshake. A partial frame is closed and
// padded with abstain (all zero) after TIMEOUT idle cycles.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   vote_in        ballot; must be one-hot to be accepted
//   vote_valid     vote_in is valid this cycle
//   vote_ready     collector can take a ballot (combinational from state)
//   a0..a4         buffered ballots; slot n holds the n-th accepted ballot
//   ballot_valid   frame complete and stable
//   ballot_ack     downstream has consumed the frame
//   timeout_flag   presented frame was closed by timeout
//   err_count      saturating count of rejected ballots
module vote_collector #(
  parameter int VW      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [VW-1:0] vote_in,
  input  logic          vote_valid,
  output logic          vote_ready,
  output logic [VW-1:0] a0,
  output logic [VW-1:0] a1,
  output logic [VW-1:0] a2,
  output logic [VW-1:0] a3,
  output logic [VW-1:0] a4,
  output logic          ballot_valid,
  input  logic          ballot_ack,
  output logic          timeout_flag,
  output logic [7:0]    err_count
);

  typedef enum logic {COLLECT, PRESENT} state_t;

  // The frame closes on the idle edge that would bring the timer to TIMEOUT.
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

  state_t        state;
  logic          live;      // low during reset and for the first cycle after it
  logic [2:0]    count;
  logic [15:0]   idle;
  logic [VW-1:0] slot [5];
  logic          one_hot;
  logic          take;

  assign one_hot    = (vote_in != '0) && ((vote_in & (vote_in - VW'(1))) == '0);
  assign vote_ready = live && (state == COLLECT);
  assign take       = vote_valid && vote_ready;

  assign a0 = slot[0];
  assign a1 = slot[1];
  assign a2 = slot[2];
  assign a3 = slot[3];
  assign a4 = slot[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= COLLECT;
      live         <= 1'b0;
      count        <= '0;
      idle         <= '0;
      ballot_valid <= 1'b0;
      timeout_flag <= 1'b0;
      err_count    <= '0;
      for (int unsigned i = 0; i < 5; i++) slot[i] <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        COLLECT: begin
          if (take && one_hot) begin
            // An accepted ballot always wins over a timer expiring on the same edge.
            for (int unsigned i = 0; i < 5; i++)
              if (3'(i) == count) slot[i] <= vote_in;
            idle <= '0;
            if (count == 3'd4) begin
              state        <= PRESENT;
              ballot_valid <= 1'b1;
              timeout_flag <= 1'b0;
            end
            count <= count + 3'd1;
          end else begin
            if (take && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            // The timer only runs once a frame has at least one ballot.
            if (count != '0) begin
              idle <= idle + 16'd1;
              if (idle == IDLE_LAST) begin
                for (int unsigned i = 0; i < 5; i++)
                  if (3'(i) >= count) slot[i] <= '0;
                state        <= PRESENT;
                ballot_valid <= 1'b1;
                timeout_flag <= 1'b1;
              end
            end
          end
        end
        PRESENT: begin
          if (ballot_ack) begin
            state        <= COLLECT;
            count        <= '0;
            idle         <= '0;
            ballot_valid <= 1'b0;
            timeout_flag <= 1'b0;
            for (int unsigned i = 0; i < 5; i++) slot[i] <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_collector.sv
module tb_vote_collector;
  localparam int VW  = 3;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [VW-1:0] vote_in = '0;
  logic          vote_valid = 1'b0;
  logic          vote_ready;
  logic [VW-1:0] a0, a1, a2, a3, a4;
  logic          ballot_valid;
  logic          ballot_ack = 1'b0;
  logic          timeout_flag;
  logic [7:0]    err_count;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {timeout_flag, a4, a3, a2, a1, a0}
  logic [15:0]   sb[$];
  logic [VW-1:0] pend[$];
  int            exp_err = 0;

  always #5 clk = ~clk;

  vote_collector #(.VW(VW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .vote_in(vote_in), .vote_valid(vote_valid),
    .vote_ready(vote_ready), .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .ballot_valid(ballot_valid), .ballot_ack(ballot_ack),
    .timeout_flag(timeout_flag), .err_count(err_count)
  );

  function automatic logic [15:0] cur_frame();
    return {timeout_flag, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [15:0] pack_pend(input logic flag);
    logic [VW-1:0] s [5];
    for (int i = 0; i < 5; i++) s[i] = (i < pend.size()) ? pend[i] : '0;
    return {flag, s[4], s[3], s[2], s[1], s[0]};
  endfunction

  // Reference model of one accepted handshake.
  function automatic void model_vote(input logic [VW-1:0] v);
    int ones = 0;
    for (int i = 0; i < VW; i++) if (v[i]) ones++;
    if (ones == 1) begin
      pend.push_back(v);
      if (pend.size() == 5) begin
        sb.push_back(pack_pend(1'b0));
        pend.delete();
      end
    end else if (exp_err < 255) begin
      exp_err++;
    end
  endfunction

  function automatic void model_timeout();
    sb.push_back(pack_pend(1'b1));
    pend.delete();
  endfunction

  // Drive one ballot for one handshake edge (inputs change at posedge+1).
  task automatic send(input logic [VW-1:0] v);
    vote_valid = 1'b1;
    vote_in    = v;
    @(posedge clk);
    model_vote(v);
    #1;
    vote_valid = 1'b0;
    vote_in    = '0;
  endtask

  task automatic pulse_ack();
    ballot_ack = 1'b1;
    @(posedge clk);
    #1;
    ballot_ack = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      if (ballot_valid) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a4, a3, a2, a1, a0} !== 15'd0 || ballot_valid !== 1'b0 || timeout_flag !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got a=%h valid=%b tflag=%b err=%0d, want a=0 valid=0 tflag=0 err=0",
               {a4, a3, a2, a1, a0}, ballot_valid, timeout_flag, err_count);
    end
    checks++;
    if (vote_ready !== 1'b0) begin errors++; $display("FAIL ready_in_reset: got %b want 0", vote_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (vote_ready !== 1'b0) begin errors++; $display("FAIL ready_after_deassert: got %b want 0", vote_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (vote_ready !== 1'b1) begin errors++; $display("FAIL ready_next_cycle: got %b want 1", vote_ready); end
    pend.delete();
    sb.delete();
    exp_err = 0;
  endtask

  task automatic test_full_frame();
    logic [15:0] exp;
    send(3'b100); send(3'b100); send(3'b010); send(3'b010);
    checks++;
    if (ballot_valid !== 1'b0) begin errors++; $display("FAIL valid_before_5th: got %b want 0", ballot_valid); end
    send(3'b001);
    checks++;
    if (ballot_valid !== 1'b1 || vote_ready !== 1'b0) begin
      errors++; $display("FAIL full_latency: got valid=%b ready=%b want valid=1 ready=0", ballot_valid, vote_ready);
    end
    exp = sb.pop_front();
    checks++;
    if (cur_frame() !== exp) begin errors++; $display("FAIL full_frame: got %h want %h", cur_frame(), exp); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (cur_frame() !== exp || ballot_valid !== 1'b1) begin
        errors++; $display("FAIL full_hold[%0d]: got %h valid=%b want %h valid=1", i, cur_frame(), ballot_valid, exp);
      end
    end
    @(posedge clk); #1;
    pulse_ack();
    checks++;
    if (ballot_valid !== 1'b0 || vote_ready !== 1'b1 || {a4, a3, a2, a1, a0} !== 15'd0) begin
      errors++; $display("FAIL after_ack: got valid=%b ready=%b a=%h want 0 1 0", ballot_valid, vote_ready, {a4, a3, a2, a1, a0});
    end
  endtask

  task automatic test_malformed();
    logic [VW-1:0] seq [8] = '{3'b100, 3'b011, 3'b010, 3'b000, 3'b001, 3'b111, 3'b100, 3'b010};
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) send(seq[i]);
    checks++;
    if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL malformed_err: got %0d want %0d", err_count, exp_err); end
    checks++;
    if (ballot_valid !== 1'b1 || sb.size() != 1) begin
      errors++; $display("FAIL malformed_valid: got valid=%b queued=%0d want 1 1", ballot_valid, sb.size());
    end else begin
      exp = sb.pop_front();
      checks++;
      if (cur_frame() !== exp) begin errors++; $display("FAIL malformed_frame: got %h want %h", cur_frame(), exp); end
    end
    pulse_ack();
  endtask

  task automatic test_timeout();
    int cycles;
    logic [15:0] exp;
    // ack while collecting must be ignored
    ballot_ack = 1'b1;
    send(3'b010);
    ballot_ack = 1'b0;
    send(3'b001);
    wait_valid(20, cycles);
    checks++;
    if (cycles != TMO) begin errors++; $display("FAIL timeout_latency: got %0d cycles want %0d", cycles, TMO); end
    model_timeout();
    exp = sb.pop_front();
    checks++;
    if (cur_frame() !== exp) begin errors++; $display("FAIL timeout_frame: got %h want %h", cur_frame(), exp); end
    pulse_ack();
    // 5th ballot lands on the edge the timer would expire: full frame wins
    send(3'b001); send(3'b010); send(3'b100); send(3'b001);
    repeat (TMO - 1) @(posedge clk);
    #1;
    checks++;
    if (ballot_valid !== 1'b0) begin errors++; $display("FAIL timeout_early: got valid=%b want 0", ballot_valid); end
    send(3'b100);
    exp = sb.pop_front();
    checks++;
    if (ballot_valid !== 1'b1 || cur_frame() !== exp) begin
      errors++; $display("FAIL race_frame: got valid=%b frame=%h want 1 %h", ballot_valid, cur_frame(), exp);
    end
    pulse_ack();
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    logic [VW-1:0] junk [3] = '{3'b001, 3'b011, 3'b100};
    send(3'b010); send(3'b010); send(3'b010); send(3'b001); send(3'b100);
    exp = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      vote_valid = 1'b1;
      vote_in    = junk[i];
      @(negedge clk);
      checks++;
      if (vote_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, vote_ready); end
      @(posedge clk); #1;
    end
    vote_valid = 1'b0;
    checks++;
    if (cur_frame() !== exp || err_count !== 8'(exp_err) || ballot_valid !== 1'b1) begin
      errors++; $display("FAIL bp_hold: got %h err=%0d valid=%b want %h err=%0d valid=1",
                         cur_frame(), err_count, ballot_valid, exp, exp_err);
    end
    pulse_ack();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) send(3'b011);
    checks++;
    if (err_count !== 8'd255 || exp_err != 255) begin
      errors++; $display("FAIL err_saturate: got %0d want 255", err_count);
    end
    checks++;
    if (ballot_valid !== 1'b0) begin errors++; $display("FAIL sat_no_frame: got valid=%b want 0", ballot_valid); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] exp;
    send(3'b100); send(3'b010); send(3'b001);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a4, a3, a2, a1, a0} !== 15'd0 || vote_ready !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("FAIL async_reset: got a=%h ready=%b err=%0d want 0 0 0", {a4, a3, a2, a1, a0}, vote_ready, err_count);
    end
    #1 rst_n = 1'b1;
    pend.delete();
    exp_err = 0;
    @(posedge clk); #1;
    send(3'b001); send(3'b001); send(3'b001); send(3'b010); send(3'b100);
    exp = sb.pop_front();
    checks++;
    if (ballot_valid !== 1'b1 || cur_frame() !== exp) begin
      errors++; $display("FAIL fresh_frame: got valid=%b frame=%h want 1 %h", ballot_valid, cur_frame(), exp);
    end
    pulse_ack();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_malformed();
    test_timeout();
    test_backpressure();
    test_saturation();
    test_reset_midframe();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d leftover want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
